ring_slot_sched: RTL and testbench

RING_SLOT_SCHED -- requirements
Module: ring_slot_sched

---
 rtl/ring_slot_sched_if.sv | 40 ++++
 rtl/ring_slot_sched.sv | 154 +++++++++++++++
 tb/tb_ring_slot_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ring_slot_sched_if.sv
// Ring slot scheduler bus: incoming ring slot, queue heads, injected slot and queue pops.
// Pure wiring, no latency.
// Backpressure arrives as inhibit/wdqAlmostFull and the queue empty flags; pops are rdMQ/rdResend.
interface ring_slot_sched_if;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn;
  logic [3:0]  SrcDestIn;
  logic        inhibit;
  logic        wdqAlmostFull;
  logic        mqEmpty;
  logic [31:0] mqOut;
  logic [3:0]  mqType;
  logic [3:0]  mqSrcDest;
  logic        resendEmpty;
  logic [31:0] resendOut;
  logic [3:0]  resendType;
  logic [3:0]  resendDest;
  logic        wrMQ;
  logic        rdMQ;
  logic        rdResend;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut;
  logic [3:0]  SrcDestOut;
  logic        tokenLost;
  logic [2:0]  state;

  modport master (
    output RingIn, SlotTypeIn, SrcDestIn, inhibit, wdqAlmostFull,
           mqEmpty, mqOut, mqType, mqSrcDest,
           resendEmpty, resendOut, resendType, resendDest,
    input  wrMQ, rdMQ, rdResend, RingOut, SlotTypeOut, SrcDestOut, tokenLost, state
  );

  modport slave (
    input  RingIn, SlotTypeIn, SrcDestIn, inhibit, wdqAlmostFull,
           mqEmpty, mqOut, mqType, mqSrcDest,
           resendEmpty, resendOut, resendType, resendDest,
    output wrMQ, rdMQ, rdResend, RingOut, SlotTypeOut, SrcDestOut, tokenLost, state
  );
endinterface

// File: rtl/ring_slot_sched.sv
// Ring slot scheduler: circulates one token, drains message and resend queues into free ring slots.
// Latency: wrMQ and the injected slot are combinational from inputs/state; state moves each clock.
// Backpressure: no token issued while inhibit/wdqAlmostFull; queue pops only when the head is non-empty.
module ring_slot_sched #(
  parameter int RESEND_MAX    = 16,
  parameter int TOKEN_TIMEOUT = 1023
) (
  input  logic clock,
  input  logic reset,
  ring_slot_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEND_TOKEN  = 3'd1,
    WAIT_TOKEN  = 3'd2,
    WAIT_DATA   = 3'd3,
    WAIT_MQ     = 3'd4,
    READ_MQ     = 3'd5,
    READ_RESEND = 3'd6
  } stateT;

  localparam logic [7:0] CNT_LAST     = 8'(RESEND_MAX - 1);
  localparam logic [9:0] TIMEOUT_LAST = 10'(TOKEN_TIMEOUT - 1);

  stateT       curState;
  stateT       nxtState;
  stateT       afterResend;
  stateT       afterMq;
  stateT       nextChoice;
  logic [7:0]  burst;
  logic        mqLoaded;
  logic [7:0]  cnt;
  logic [9:0]  tokTimer;
  logic        ok;
  logic        tokenSeen;
  logic        ringToMq;
  logic        popMq;
  logic        popResend;
  logic        lostPulse;
  logic [31:0] outData;
  logic [3:0]  outType;
  logic [3:0]  outDest;

  assign ok        = ~bus.inhibit & ~bus.wdqAlmostFull;
  assign tokenSeen = (bus.SlotTypeIn == 4'd1);

  // Ring-travelling slots addressed to someone, and unsolicited addresses, go to the message queue.
  assign ringToMq = (bus.SlotTypeIn[3] & (bus.SrcDestIn != 4'd0))
                  | ((bus.SlotTypeIn == 4'd2) & bus.RingIn[28] & ~bus.RingIn[31]);

  // Work priority after a round: queued messages, then resends, then a fresh token if allowed.
  assign afterResend = ok ? SEND_TOKEN : IDLE;
  assign afterMq     = bus.resendEmpty ? afterResend : READ_RESEND;
  assign nextChoice  = mqLoaded ? WAIT_MQ : afterMq;

  // Next-state and queue-pop decode.
  always_comb begin
    nxtState  = curState;
    popMq     = 1'b0;
    popResend = 1'b0;
    lostPulse = 1'b0;
    case (curState)
      IDLE:       nxtState = nextChoice;
      SEND_TOKEN: nxtState = WAIT_TOKEN;
      WAIT_TOKEN: begin
        if (tokenSeen) begin
          nxtState = WAIT_DATA;
        end else if (tokTimer == TIMEOUT_LAST) begin
          lostPulse = 1'b1;
          nxtState  = IDLE;
        end
      end
      WAIT_DATA: begin
        if (burst == 8'd0) nxtState = nextChoice;
      end
      WAIT_MQ: begin
        // The queue may report empty for a cycle or two after the write landed.
        if (!bus.mqEmpty) nxtState = READ_MQ;
      end
      READ_MQ: begin
        popMq = ~bus.mqEmpty;
        if (bus.mqEmpty) nxtState = afterMq;
      end
      READ_RESEND: begin
        popResend = ~bus.resendEmpty;
        if (bus.resendEmpty || (cnt == CNT_LAST)) nxtState = afterResend;
      end
      default: nxtState = IDLE;
    endcase
  end

  // State register; reset drops any token in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) curState <= IDLE;
    else        curState <= nxtState;
  end

  // Burst length of the data following the returned token, counted down one slot per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                burst <= 8'd0;
    else if (tokenSeen)        burst <= bus.RingIn[7:0];
    else if (burst != 8'd0)    burst <= burst - 8'd1;
  end

  // Remembers that the message queue was written; a write in the same cycle as a pop wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        mqLoaded <= 1'b0;
    else if (ringToMq) mqLoaded <= 1'b1;
    else if (popMq)    mqLoaded <= 1'b0;
  end

  // Resend pops in the current visit; zero whenever outside READ_RESEND.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       cnt <= 8'd0;
    else if (curState != READ_RESEND) cnt <= 8'd0;
    else if (popResend)               cnt <= cnt + 8'd1;
  end

  // Cycles spent waiting for the token to come back around.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                                 tokTimer <= 10'd0;
    else if ((curState == WAIT_TOKEN) && (nxtState == WAIT_TOKEN)) tokTimer <= tokTimer + 10'd1;
    else                                                        tokTimer <= 10'd0;
  end

  // Injected slot: token, message head (Address becomes AddressRequest), resend head, else Null.
  always_comb begin
    outType = 4'd7;
    outData = 32'd0;
    outDest = 4'd0;
    if (curState == SEND_TOKEN) begin
      outType = 4'd1;
    end else if (popMq) begin
      outType = (bus.mqType == 4'd2) ? 4'd5 : bus.mqType;
      outData = bus.mqOut;
      outDest = bus.mqSrcDest;
    end else if (popResend) begin
      outType = bus.resendType;
      outData = bus.resendOut;
      outDest = bus.resendDest;
    end
  end

  assign bus.wrMQ        = ringToMq;
  assign bus.rdMQ        = popMq;
  assign bus.rdResend    = popResend;
  assign bus.tokenLost   = lostPulse;
  assign bus.RingOut     = outData;
  assign bus.SlotTypeOut = outType;
  assign bus.SrcDestOut  = outDest;
  assign bus.state       = curState;

endmodule

// File: tb/tb_ring_slot_sched.sv
// Bench for ring_slot_sched: directed rounds plus random traffic against a behavioural model.
// Model tracks the slot-scheduling rules per cycle; queues are bench-side SV queues.
// Every comparison goes through checkVal.
module tb_ring_slot_sched;
  localparam int RESEND_MAX    = 16;
  localparam int TOKEN_TIMEOUT = 1023;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ring_slot_sched_if bus();

  ring_slot_sched #(.RESEND_MAX(RESEND_MAX), .TOKEN_TIMEOUT(TOKEN_TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // external queues, entry = {data, type, srcdest}
  logic [39:0] mq[$];
  logic [39:0] rq[$];

  // behavioural model
  int mState, mBurst, mCnt, mWait;
  bit mLoaded;

  // DUT-observed event counters
  int tokCount = 0, addrCount = 0, popCount = 0, lostCount = 0;
  bit gotFirstMq = 0;
  logic [31:0] fmData;
  logic [3:0]  fmType, fmDest;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic driveHeads();
    bus.mqEmpty = (mq.size() == 0);
    if (mq.size() != 0) {bus.mqOut, bus.mqType, bus.mqSrcDest} = mq[0];
    else {bus.mqOut, bus.mqType, bus.mqSrcDest} = {$urandom, 8'($urandom)};
    bus.resendEmpty = (rq.size() == 0);
    if (rq.size() != 0) {bus.resendOut, bus.resendType, bus.resendDest} = rq[0];
    else {bus.resendOut, bus.resendType, bus.resendDest} = {$urandom, 8'($urandom)};
  endtask

  // One clock: drive a ring slot, compare against model at negedge, advance model at posedge.
  task automatic cyc(input logic [3:0] t, input logic [31:0] d, input logic [3:0] sd);
    bit ok, mqE, rsE, eWr, eRdMq, eRdRs, eLost;
    int choice, nxt;
    logic [3:0] eType, eDest;
    logic [31:0] eData;
    bus.SlotTypeIn = t;
    bus.RingIn     = d;
    bus.SrcDestIn  = sd;
    driveHeads();
    mqE = (mq.size() == 0);
    rsE = (rq.size() == 0);
    ok  = !bus.inhibit && !bus.wdqAlmostFull;
    choice = mLoaded ? 4 : (!rsE ? 6 : (ok ? 1 : 0));
    eWr   = (t >= 8 && sd != 0) || (t == 2 && d[28] && !d[31]);
    eRdMq = (mState == 5) && !mqE;
    eRdRs = (mState == 6) && !rsE;
    eLost = (mState == 2) && (t != 1) && (mWait == TOKEN_TIMEOUT - 1);
    eType = 4'd7; eData = 32'd0; eDest = 4'd0;
    if (mState == 1) eType = 4'd1;
    else if (eRdMq) begin
      {eData, eType, eDest} = mq[0];
      if (eType == 4'd2) eType = 4'd5;
    end else if (eRdRs) {eData, eType, eDest} = rq[0];
    case (mState)
      0: nxt = choice;
      1: nxt = 2;
      2: nxt = (t == 1) ? 3 : (eLost ? 0 : 2);
      3: nxt = (mBurst != 0) ? 3 : choice;
      4: nxt = mqE ? 4 : 5;
      5: nxt = mqE ? (!rsE ? 6 : (ok ? 1 : 0)) : 5;
      6: nxt = (rsE || (mCnt == RESEND_MAX - 1)) ? (ok ? 1 : 0) : 6;
      default: nxt = 0;
    endcase
    @(negedge clock);
    checkVal("state", 32'(bus.state), 32'(mState));
    checkVal("wrMQ", 32'(bus.wrMQ), 32'(eWr));
    checkVal("rdMQ", 32'(bus.rdMQ), 32'(eRdMq));
    checkVal("rdResend", 32'(bus.rdResend), 32'(eRdRs));
    checkVal("tokenLost", 32'(bus.tokenLost), 32'(eLost));
    checkVal("SlotTypeOut", 32'(bus.SlotTypeOut), 32'(eType));
    checkVal("RingOut", bus.RingOut, eData);
    checkVal("SrcDestOut", 32'(bus.SrcDestOut), 32'(eDest));
    if (bus.SlotTypeOut == 4'd1) tokCount++;
    if (bus.SlotTypeOut == 4'd5) addrCount++;
    if (bus.rdResend)  popCount++;
    if (bus.tokenLost) lostCount++;
    if (bus.rdMQ && !gotFirstMq) begin
      gotFirstMq = 1;
      fmData = bus.RingOut; fmType = bus.SlotTypeOut; fmDest = bus.SrcDestOut;
    end
    @(posedge clock);
    mBurst  = (t == 1) ? int'(d[7:0]) : ((mBurst != 0) ? mBurst - 1 : mBurst);
    mLoaded = eWr ? 1'b1 : (eRdMq ? 1'b0 : mLoaded);
    mCnt    = (mState == 6) ? mCnt + int'(eRdRs) : 0;
    mWait   = (mState == 2 && nxt == 2) ? mWait + 1 : 0;
    mState  = nxt;
    if (eRdMq) void'(mq.pop_front());
    if (eRdRs) void'(rq.pop_front());
    if (eWr) mq.push_back({d, t, sd});
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkVal("rst_state", 32'(bus.state), 32'd0);
    checkVal("rst_type", 32'(bus.SlotTypeOut), 32'd7);
    checkVal("rst_data", bus.RingOut, 32'd0);
    checkVal("rst_dest", 32'(bus.SrcDestOut), 32'd0);
    checkVal("rst_rdMQ", 32'(bus.rdMQ), 32'd0);
    checkVal("rst_rdResend", 32'(bus.rdResend), 32'd0);
    checkVal("rst_tokenLost", 32'(bus.tokenLost), 32'd0);
    bus.SlotTypeIn = 4'd8; bus.SrcDestIn = 4'd3;
    #1 checkVal("rst_wrMQ_on", 32'(bus.wrMQ), 32'd1);
    bus.SlotTypeIn = 4'd7; bus.SrcDestIn = 4'd0;
    #1 checkVal("rst_wrMQ_off", 32'(bus.wrMQ), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    mState = 0; mBurst = 0; mLoaded = 0; mCnt = 0; mWait = 0;
  endtask

  task automatic runUntilState(input int s, input int budget, input string tag);
    int n = 0;
    while (mState != s && n < budget) begin
      cyc(4'd7, 32'd0, 4'd0);
      n++;
    end
    checkVal(tag, 32'(bus.state), 32'(s));
  endtask

  initial begin
    int tb0, pc0;
    logic [3:0] t;
    reset = 1'b1;
    bus.inhibit = 1'b0; bus.wdqAlmostFull = 1'b0;
    bus.RingIn = 32'd0; bus.SlotTypeIn = 4'd7; bus.SrcDestIn = 4'd0;
    driveHeads();
    #2 doReset();

    // basic token round, burst 4
    repeat (5) cyc(4'd7, 32'd0, 4'd0);
    cyc(4'd1, 32'd4, 4'd0);
    repeat (6) cyc(4'd7, 32'd0, 4'd0);
    checkVal("a_tokens", 32'(tokCount), 32'd2);
    checkVal("a_state", 32'(bus.state), 32'd2);

    // ring slots captured into the message queue, replayed after the burst
    repeat (2) cyc(4'd7, 32'd0, 4'd0);
    cyc(4'd1, 32'd6, 4'd0);
    cyc(4'd8, 32'hDEADBEEF, 4'd3);
    cyc(4'd2, 32'h1000_0055, 4'd9);
    repeat (14) cyc(4'd7, 32'd0, 4'd0);
    checkVal("b_first_type", 32'(fmType), 32'd8);
    checkVal("b_first_dest", 32'(fmDest), 32'd3);
    checkVal("b_first_data", fmData, 32'hDEADBEEF);
    checkVal("b_addr_req", 32'(addrCount), 32'd1);

    // 20 resends split across two visits
    for (int i = 0; i < 20; i++) rq.push_back({32'hA000_0000 + 32'(i), 4'(8 + i % 8), 4'(i)});
    runUntilState(2, 40, "c_wait_tok1");
    popCount = 0;
    cyc(4'd1, 32'd0, 4'd0);
    runUntilState(1, 40, "c_send_tok1");
    checkVal("c_first_visit", 32'(popCount), 32'(RESEND_MAX));
    runUntilState(2, 10, "c_wait_tok2");
    cyc(4'd1, 32'd0, 4'd0);
    runUntilState(1, 40, "c_send_tok2");
    checkVal("c_second_visit", 32'(popCount), 32'd20);

    // token lost
    lostCount = 0; tb0 = tokCount;
    repeat (TOKEN_TIMEOUT + 3) cyc(4'd7, 32'd0, 4'd0);
    checkVal("d_lost_pulses", 32'(lostCount), 32'd1);
    checkVal("d_tokens", 32'(tokCount - tb0), 32'd2);
    checkVal("d_state", 32'(bus.state), 32'd2);

    // inhibit: round in progress completes, no new token, resends still drained
    bus.inhibit = 1'b1;
    cyc(4'd1, 32'd2, 4'd0);
    tb0 = tokCount; pc0 = popCount;
    for (int i = 0; i < 5; i++) rq.push_back({$urandom, 4'(9), 4'(i)});
    for (int i = 0; i < 40; i++) begin
      t = 4'($urandom_range(0, 15));
      if (t == 4'd1) t = 4'd7;
      cyc(t, $urandom & 32'hFFFF_FF00, 4'($urandom));
    end
    repeat (30) cyc(4'd7, 32'd0, 4'd0);
    checkVal("e_no_token", 32'(tokCount - tb0), 32'd0);
    checkVal("e_resend_drained", 32'(popCount - pc0), 32'd5);

    // reset in the middle of READ_MQ
    for (int i = 0; i < 8; i++) cyc(4'd8, 32'(i), 4'd5);
    runUntilState(5, 20, "g_read_mq");
    cyc(4'd7, 32'd0, 4'd0);
    doReset();
    bus.inhibit = 1'b0;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.inhibit       = ($urandom_range(0, 7) == 0);
      bus.wdqAlmostFull = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) rq.push_back({$urandom, 8'($urandom)});
      if ($urandom_range(0, 31) == 0) t = 4'd1;
      else begin
        t = 4'($urandom_range(0, 15));
        if (t == 4'd1) t = 4'd7;
      end
      cyc(t, {$urandom_range(0, 255) << 24, 16'($urandom), 8'($urandom_range(0, 5))}, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
